// File: rtl/comb_eval_arbiter.sv
// Round-robin arbiter sharing one combinational A-E -> F/G evaluator among N_REQ requesters.
// Optional self-test sweep of all 32 evaluator vectors is enabled with `define COMB_ARB_SWEEP_EN.
module comb_eval_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [5*N_REQ-1:0]   req_vec,
  output logic [N_REQ-1:0]     req_ready,
  output logic [4:0]           cc_abcde,
  input  logic                 cc_f,
  input  logic                 cc_g,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_fg,
  output logic [ID_W-1:0]      rsp_id
`ifdef COMB_ARB_SWEEP_EN
  ,
  input  logic                 sweep_start,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [5:0]           sweep_f_ones,
  output logic [5:0]           sweep_g_ones
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and a raised rsp_valid holds its payload until accepted.

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    RESP
`ifdef COMB_ARB_SWEEP_EN
    ,
    SWEEP
`endif
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            any_req;
  logic            accept;
  int              idx;

  // Scan from the farthest offset down so the nearest valid requester at/after rr_ptr wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        grant   = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

`ifdef COMB_ARB_SWEEP_EN
  logic       sweep_go;
  logic [5:0] sweep_idx;

  assign sweep_go   = (state == IDLE) && sweep_start && rst_n;
  assign accept     = (state == IDLE) && any_req && !sweep_start && rst_n;
  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == SWEEP) && (sweep_idx == 6'd32);
`else
  assign accept = (state == IDLE) && any_req && rst_n;
`endif

  assign req_ready = accept ? (N_REQ'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef COMB_ARB_SWEEP_EN
        if (sweep_go) state_nxt = SWEEP;
        else
`endif
        if (accept) state_nxt = DRIVE;
      end
      DRIVE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
`ifdef COMB_ARB_SWEEP_EN
      SWEEP:   if (sweep_idx == 6'd32) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_abcde  <= 5'b0;
      rsp_valid <= 1'b0;
      rsp_fg    <= 2'b0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        cc_abcde <= req_vec[5*grant +: 5];
        rsp_id   <= grant;
        rr_ptr   <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end
      if (state == CAPTURE) begin
        rsp_fg    <= {cc_f, cc_g};
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
`ifdef COMB_ARB_SWEEP_EN
      if (sweep_go) begin
        cc_abcde <= 5'b0;
      end else if ((state == SWEEP) && (sweep_idx < 6'd31)) begin
        cc_abcde <= cc_abcde + 5'd1;
      end
`endif
    end
  end

`ifdef COMB_ARB_SWEEP_EN
  // Vector k is on cc_abcde during sweep cycle k; its F/G land in the counters one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx    <= 6'd0;
      sweep_f_ones <= 6'd0;
      sweep_g_ones <= 6'd0;
    end else if (sweep_go) begin
      sweep_idx    <= 6'd0;
      sweep_f_ones <= 6'd0;
      sweep_g_ones <= 6'd0;
    end else if ((state == SWEEP) && (sweep_idx < 6'd32)) begin
      sweep_idx    <= sweep_idx + 6'd1;
      sweep_f_ones <= sweep_f_ones + {5'd0, cc_f};
      sweep_g_ones <= sweep_g_ones + {5'd0, cc_g};
    end
  end
`endif

endmodule

// File: tb/tb_comb_eval_arbiter.sv
// Randomized self-checking bench for comb_eval_arbiter with a golden evaluator and a
// transaction-level round-robin model; sweep checks compile in with COMB_ARB_SWEEP_EN.
module tb_comb_eval_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = $clog2(N_REQ);
  localparam int VW    = 5 * N_REQ;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [VW-1:0]      req_vec;
  logic [N_REQ-1:0]   req_ready;
  logic [4:0]         cc_abcde;
  logic               cc_f;
  logic               cc_g;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_fg;
  logic [ID_W-1:0]    rsp_id;
`ifdef COMB_ARB_SWEEP_EN
  logic               sweep_start;
  logic               sweep_busy;
  logic               sweep_done;
  logic [5:0]         sweep_f_ones;
  logic [5:0]         sweep_g_ones;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 0;
  logic [7:0] exp_q[$];

  comb_eval_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_vec(req_vec),
    .req_ready(req_ready),
    .cc_abcde(cc_abcde),
    .cc_f(cc_f),
    .cc_g(cc_g),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_fg(rsp_fg),
    .rsp_id(rsp_id)
`ifdef COMB_ARB_SWEEP_EN
    ,
    .sweep_start(sweep_start),
    .sweep_busy(sweep_busy),
    .sweep_done(sweep_done),
    .sweep_f_ones(sweep_f_ones),
    .sweep_g_ones(sweep_g_ones)
`endif
  );

  // Golden evaluator: F = ~E & (~C | D), G = B & C & ~D & ~E.
  function automatic logic [1:0] eval_fg(input logic [4:0] v);
    logic b, c, d, e;
    b = v[3];
    c = v[2];
    d = v[1];
    e = v[0];
    return {~e & (~c | d), b & c & ~d & ~e};
  endfunction

  assign {cc_f, cc_g} = eval_fg(cc_abcde);

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the winner is the valid requester with the smallest upward distance from the pointer.
  function automatic int model_grant(input logic [N_REQ-1:0] mask);
    int best;
    int best_d;
    int d;
    best   = -1;
    best_d = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (mask[i]) begin
        d = (i - model_ptr + N_REQ) % N_REQ;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  // Driver: called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic run_txn(input logic [N_REQ-1:0] mask, input logic [VW-1:0] vecs, input int stall);
    int g;
    logic [4:0] v;
    logic [7:0] e;
    req_valid = mask;
    req_vec   = vecs;
    rsp_ready = (stall == 0);
    g = model_grant(mask);
    v = vecs[5*g +: 5];
    #1;
    check("grant", req_ready, 32'(1) << g);
    exp_q.push_back({2'b00, 4'(g), eval_fg(v)});
    @(posedge clk);
    model_ptr = (g + 1) % N_REQ;
    @(negedge clk);
    check("cc_abcde", cc_abcde, v);
    check("drive_ready", req_ready, 0);
    check("drive_valid", rsp_valid, 0);
    @(negedge clk);
    check("capture_valid", rsp_valid, 0);
    check("capture_vec", cc_abcde, v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, e[7:2]);
    check("rsp_fg", rsp_fg, e[1:0]);
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, e[7:2]);
      check("hold_fg", rsp_fg, e[1:0]);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rsp_done", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  task automatic idle_gap(input int cycles);
    logic [4:0] held;
    held = cc_abcde;
    req_valid = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("idle_ready", req_ready, 0);
      check("idle_valid", rsp_valid, 0);
      check("idle_hold", cc_abcde, held);
    end
  endtask

  initial begin
    logic [VW-1:0] vecs;
    logic [N_REQ-1:0] mask;
    logic [4:0] dir_vec[4];
    rst_n     = 1'b0;
    req_valid = '1;
    req_vec   = '0;
    rsp_ready = 1'b0;
`ifdef COMB_ARB_SWEEP_EN
    sweep_start = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_cc", cc_abcde, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_fg", rsp_fg, 0);
    check("rst_id", rsp_id, 0);
    rst_n = 1'b1;
    req_valid = '0;
    @(negedge clk);

    // Directed evaluator vectors on requester 0, response accepted as soon as it appears
    dir_vec[0] = 5'b00000;
    dir_vec[1] = 5'b01100;
    dir_vec[2] = 5'b01110;
    dir_vec[3] = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      vecs = VW'($urandom);
      vecs[4:0] = dir_vec[i];
      run_txn(N_REQ'(1), vecs, 0);
    end

    // Backpressure for 10 cycles
    run_txn(N_REQ'(2), VW'($urandom), 10);
    idle_gap(3);

    // Pointer to 3, then only 1 and 3 valid: expect 3 then 1, pointer ends at 2
    run_txn(N_REQ'(4), VW'($urandom), 0);
    run_txn(N_REQ'(10), VW'($urandom), 0);
    run_txn(N_REQ'(10), VW'($urandom), 1);
    run_txn('1, VW'($urandom), 0);

    // Reset during CAPTURE
    req_valid = N_REQ'(4);
    req_vec   = VW'($urandom);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cc", cc_abcde, 0);
    check("midrst_valid", rsp_valid, 0);
    check("midrst_id", rsp_id, 0);
    check("midrst_fg", rsp_fg, 0);
    check("midrst_ready", req_ready, 0);
    model_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    @(negedge clk);

    // Fairness from power-up pointer: all valid, expect 0,1,2,3,0
    for (int i = 0; i < 5; i++) run_txn('1, VW'($urandom), 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_txn(mask, VW'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

`ifdef COMB_ARB_SWEEP_EN
    begin
      int f_exp;
      int g_exp;
      int busy_cycles;
      int done_pulses;
      logic [1:0] fg;
      f_exp = 0;
      g_exp = 0;
      for (int k = 0; k < 32; k++) begin
        fg = eval_fg(5'(k));
        f_exp += int'(fg[1]);
        g_exp += int'(fg[0]);
      end
      busy_cycles = 0;
      done_pulses = 0;
      req_valid   = '1;
      req_vec     = VW'($urandom);
      sweep_start = 1'b1;
      #1;
      check("sweep_prio_ready", req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      sweep_start = 1'b0;
      for (int c = 0; c < 40 && sweep_busy; c++) begin
        busy_cycles++;
        check("sweep_ready", req_ready, 0);
        if (sweep_done) begin
          done_pulses++;
          check("sweep_f_ones", sweep_f_ones, f_exp);
          check("sweep_g_ones", sweep_g_ones, g_exp);
        end
        @(negedge clk);
      end
      check("sweep_busy_cycles", busy_cycles, 33);
      check("sweep_done_pulses", done_pulses, 1);
      check("sweep_f_hold", sweep_f_ones, f_exp);
      run_txn('1, VW'($urandom), 0);
    end
`endif

    // Scoreboard must be drained
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
